irq_pending_latch: RTL and testbench

- Upstream stage of the 4-to-2 priority encoder (inputs D[3:0]; outputs X, Y, V).
- Synchronises four asynchronous request lines and detects their rising edges.
- Holds each detected event as a sticky pending bit until it is acknowledged by encoded index, and applies a per-line mask.
- Presents the masked pending vector as the encoder's D input. The service logic acknowledges with the encoder's {X,Y} code.

---
 rtl/irq_pending_latch.sv | 86 ++++++++
 tb/tb_irq_pending_latch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sync, edge-detect and sticky-latch four request lines
// feeding the 4-to-2 priority encoder, with mask, overflow and ack checking.
module irq_pending_latch #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] MASK_RESET  = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       ack,
  input  logic [1:0] ack_id,
  input  logic       ovf_clr,
  output logic [3:0] D,
  output logic       any_req,
  output logic [3:0] ovf,
  output logic       ack_err
);

  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_prev;
  logic [3:0] r_pend;
  logic [3:0] r_mask;
  logic [3:0] r_ovf;
  logic       r_ack_err;

  logic [3:0] w_s;
  logic [3:0] w_rise;
  logic [3:0] w_sel;
  logic [3:0] w_clr;
  logic [3:0] w_ovf_set;
  logic [3:0] w_pend_nxt;
  logic [3:0] w_ovf_nxt;
  logic       w_ack_miss;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_sel  = 4'b0001 << ack_id;

  // Ack only clears a line that is actually pending; otherwise it is an error.
  always_comb begin
    w_clr      = '0;
    w_ack_miss = 1'b0;
    if (ack) begin
      w_clr      = w_sel & r_pend;
      w_ack_miss = ~r_pend[ack_id];
    end
  end

  // A fresh event always beats a same-cycle clear.
  assign w_ovf_set  = w_rise & r_pend & ~w_clr;
  assign w_pend_nxt = w_rise | (r_pend & ~w_clr);
  assign w_ovf_nxt  = (ovf_clr ? 4'b0000 : r_ovf) | w_ovf_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        r_sync[j] <= '0;
      end
      r_prev    <= '0;
      r_pend    <= '0;
      r_mask    <= MASK_RESET;
      r_ovf     <= '0;
      r_ack_err <= 1'b0;
    end else begin
      r_sync[0] <= irq_in;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        r_sync[j] <= r_sync[j-1];
      end
      r_prev    <= w_s;
      r_pend    <= w_pend_nxt;
      if (mask_we) begin
        r_mask <= mask_in;
      end
      r_ovf     <= w_ovf_nxt;
      r_ack_err <= w_ack_miss;
    end
  end

  assign D       = r_pend & ~r_mask;
  assign any_req = |D;
  assign ovf     = r_ovf;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed scenarios plus random traffic
// compared against a sample-history reference model.
module tb_irq_pending_latch;

  localparam int S = 2;
  localparam logic [3:0] MRST = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ack;
  logic [1:0] ack_id;
  logic       ovf_clr;
  logic [3:0] d;
  logic       any_req;
  logic [3:0] ovf;
  logic       ack_err;

  int total = 0;
  int bad   = 0;

  // model state: hist[j] = irq_in sampled j+1 edges ago (0 across reset)
  logic [3:0] hist [0:S];
  logic [3:0] m_pend, m_mask, m_ovf;
  logic       m_err;

  irq_pending_latch #(.SYNC_STAGES(S), .MASK_RESET(MRST)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack), .ack_id(ack_id), .ovf_clr(ovf_clr),
    .D(d), .any_req(any_req), .ovf(ovf), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] rise, clr;
    if (!rst_n) begin
      for (int j = 0; j <= S; j++) hist[j] = '0;
      m_pend = '0;
      m_mask = MRST;
      m_ovf  = '0;
      m_err  = 1'b0;
    end else begin
      // event seen now = rising edge between samples S and S+1 edges ago
      rise = hist[S-1] & ~hist[S];
      clr  = '0;
      m_err = 1'b0;
      if (ack) begin
        if (m_pend[ack_id]) clr[ack_id] = 1'b1;
        else m_err = 1'b1;
      end
      m_ovf  = (ovf_clr ? 4'b0000 : m_ovf) | (rise & m_pend & ~clr);
      m_pend = rise | (m_pend & ~clr);
      if (mask_we) m_mask = mask_in;
      for (int j = S; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_in;
    end
  endtask

  task automatic check_all();
    chk("D", d, m_pend & ~m_mask);
    chk("any_req", {3'b0, any_req}, {3'b0, |(m_pend & ~m_mask)});
    chk("ovf", ovf, m_ovf);
    chk("ack_err", {3'b0, ack_err}, {3'b0, m_err});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    ack = 1'b0; mask_we = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] id);
    ack = 1'b1; ack_id = id;
    step();
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 4'b1111; mask_we = 1'b0; mask_in = '0;
    ack = 1'b0; ack_id = '0; ovf_clr = 1'b0;
    for (int j = 0; j <= S; j++) hist[j] = '0;
    m_pend = '0; m_mask = MRST; m_ovf = '0; m_err = 1'b0;

    // reset with lines high, then latency after release
    step(); step();
    chk("rst_D", d, 4'b0000);
    chk("rst_ovf", ovf, 4'b0000);
    rst_n = 1'b1;
    step(); chk("lat1_D", d, 4'b0000);
    step(); chk("lat2_D", d, 4'b0000);
    step(); chk("lat3_D", d, 4'b1111);
    chk("lat3_any", {3'b0, any_req}, 4'b0001);
    chk("lat3_ovf", ovf, 4'b0000);
    do_ack(2'd3); do_ack(2'd2); do_ack(2'd1); do_ack(2'd0);
    chk("drain_D", d, 4'b0000);
    irq_in = 4'b0000;
    repeat (4) step();

    // single-cycle pulse on bit 2
    irq_in = 4'b0100; step();
    irq_in = 4'b0000; step(); step();
    chk("pulse_D", d, 4'b0100);
    do_ack(2'd2);
    chk("pulse_ack_D", d, 4'b0000);
    chk("pulse_ack_err", {3'b0, ack_err}, 4'b0000);

    // simultaneous rises on 0 and 3
    irq_in = 4'b1001; step();
    irq_in = 4'b0000; step(); step();
    chk("prio_D", d, 4'b1001);
    do_ack(2'd3); chk("prio_a3", d, 4'b0001);
    do_ack(2'd0); chk("prio_a0", d, 4'b0000);

    // mask hides bit 1, unmask reveals it
    mask_we = 1'b1; mask_in = 4'b0010; step();
    irq_in = 4'b0010; step();
    irq_in = 4'b0000; step(); step();
    chk("mask_D", d, 4'b0000);
    chk("mask_any", {3'b0, any_req}, 4'b0000);
    mask_we = 1'b1; mask_in = 4'b0000; step();
    chk("unmask_D", d, 4'b0010);

    // second rise while pending -> overflow
    irq_in = 4'b0010; step();
    irq_in = 4'b0000; step(); step();
    chk("ovf_set", ovf, 4'b0010);
    // rise arriving on the edge the ack lands
    irq_in = 4'b0010; step();
    irq_in = 4'b0000; step();
    ack = 1'b1; ack_id = 2'd1; step();
    chk("sbc_D", d, 4'b0010);
    chk("sbc_ovf", ovf, 4'b0010);
    ovf_clr = 1'b1; step();
    chk("ovf_clr", ovf, 4'b0000);
    do_ack(2'd1);
    chk("clr1_D", d, 4'b0000);

    // ack to an idle line
    do_ack(2'd1);
    chk("err_pulse", {3'b0, ack_err}, 4'b0001);
    chk("err_D", d, 4'b0000);
    step();
    chk("err_gone", {3'b0, ack_err}, 4'b0000);
    chk("err_ovf", ovf, 4'b0000);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
      ack     = ($urandom_range(0, 2) == 0);
      ack_id  = 2'($urandom);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 4'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
